// File: rtl/chip8_keypad_pkg.sv
// chip8_keypad_pkg
// Shared definitions for the CHIP-8 keypad scanner:
//   KEY_W       - width of a hex key code (4)
//   KEY_MAP     - matrix position {row,col} -> CHIP-8 hex value
//   state_t     - FX0A wait FSM states
//   lowest_set  - index of the lowest set bit of a 16-bit key vector
// No ports. Related build macro: KEYPAD_RELEASE_WAIT_EN (used by the top).
package chip8_keypad_pkg;

  localparam int KEY_W = 4;

  // Entry p (p = row*4 + col) lives at bits [p*4 +: 4].
  //   row0: 1 2 3 C   row1: 4 5 6 D   row2: 7 8 9 E   row3: A 0 B F
  localparam logic [63:0] KEY_MAP = {
    4'hF, 4'hB, 4'h0, 4'hA,
    4'hE, 4'h9, 4'h8, 4'h7,
    4'hD, 4'h6, 4'h5, 4'h4,
    4'hC, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Lowest-numbered set bit wins; returns 0 for an empty vector.
  function automatic logic [KEY_W-1:0] lowest_set(input logic [15:0] v);
    lowest_set = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = KEY_W'(i);
    end
  endfunction

endpackage

// File: rtl/chip8_keypad_scan_if.sv
// chip8_keypad_scan_if
// FX0A "wait for key" handshake between the CPU core and the keypad scanner.
//   wait_req  - core -> keypad, request level
//   key_valid - keypad -> core, one-cycle completion pulse
//   key_code  - keypad -> core, captured hex key (valid with key_valid, held after)
// Handshake: the core raises wait_req and holds it high until it sees key_valid;
// key_valid is high for exactly one cycle and key_code is valid in that cycle.
// Dropping wait_req before key_valid aborts the request with no pulse.
// Modports: master = core side, slave = keypad side.
interface chip8_keypad_scan_if;
  import chip8_keypad_pkg::*;

  logic             wait_req;
  logic             key_valid;
  logic [KEY_W-1:0] key_code;

  modport master (output wait_req, input key_valid, input key_code);
  modport slave  (input wait_req, output key_valid, output key_code);
endinterface

// File: rtl/chip8_keypad_scan_key_debounce.sv
// key_debounce
// One key's debouncer: a 3-bit disagreement counter plus the debounced state.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   i_en          - sample strobe (once per full scan for this key)
//   i_raw         - raw sample, 1 = pressed
//   o_state       - debounced state, 1 = pressed
//   o_state_nxt   - value o_state takes at the next edge (for registered OR-reduce)
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_raw,
  output logic o_state,
  output logic o_state_nxt
);

  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       r_state;
  logic       w_state_nxt;

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (i_en) begin
      if (i_raw == r_state) begin
        w_cnt_nxt = 3'd0;
      end else if (r_cnt + 3'd1 == 3'(DEBOUNCE_SCANS)) begin
        w_state_nxt = ~r_state;
        w_cnt_nxt   = 3'd0;
      end else begin
        w_cnt_nxt = r_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 3'd0;
      r_state <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign o_state     = r_state;
  assign o_state_nxt = w_state_nxt;

endmodule

// File: rtl/chip8_keypad_scan.sv
// chip8_keypad_scan
// Scans the 4x4 CHIP-8 hex keypad, debounces every key into a hex-indexed
// key-down vector and services the FX0A wait-for-key handshake.
// Build macro KEYPAD_RELEASE_WAIT_EN: when defined FX0A completes on release
// of the captured key (HELD state present); when undefined it completes on press.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   o_row_n[3:0]  - row drive, active-low one-hot
//   i_col_n[3:0]  - column sense, active-low, already synchronised
//   o_key_down    - debounced key state, bit k = hex key k
//   o_any_key     - registered OR of o_key_down
//   kp            - FX0A handshake (slave side)
//   o_dbg_state   - wait FSM state
module chip8_keypad_scan
  import chip8_keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [3:0]            o_row_n,
  input  logic [3:0]            i_col_n,
  output logic [15:0]           o_key_down,
  output logic                  o_any_key,
  chip8_keypad_scan_if.slave    kp,
  output state_t                o_dbg_state
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  // ---------------- row scan ----------------
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row;
  logic             w_sample;

  // Columns are sampled on the last count of a row; the row advances on the
  // same edge so the next row is driven from the following cycle.
  assign w_sample = (r_div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_row <= 2'd0;
    end else if (w_sample) begin
      r_div <= '0;
      r_row <= r_row + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_row_n = ~(4'b0001 << r_row);

  // ---------------- per-key debounce ----------------
  logic [15:0] w_key_down;
  logic [15:0] w_key_nxt;
  logic        r_any_key;

  for (genvar p = 0; p < 16; p++) begin : g_key
    localparam int         ROW = p / 4;
    localparam int         COL = p % 4;
    localparam logic [3:0] HEX = KEY_MAP[p*4 +: 4];

    key_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_deb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (w_sample && (r_row == 2'(ROW))),
      .i_raw       (~i_col_n[COL]),
      .o_state     (w_key_down[HEX]),
      .o_state_nxt (w_key_nxt[HEX])
    );
  end

  // Built from the next-state vector so it changes on the same edge as key_down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_any_key <= 1'b0;
    else        r_any_key <= |w_key_nxt;
  end

  assign o_key_down = w_key_down;
  assign o_any_key  = r_any_key;

  // ---------------- FX0A wait FSM ----------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [KEY_W-1:0] r_key_code;
  logic [KEY_W-1:0] w_key_code_nxt;
  logic [15:0]      r_key_prev;
  logic [15:0]      w_rise;

  // Only fresh 0->1 transitions count, so keys already down when ARMED is
  // entered never complete the request.
  assign w_rise = w_key_down & ~r_key_prev;

  always_comb begin
    w_state_nxt    = r_state;
    w_key_code_nxt = r_key_code;
    case (r_state)
      IDLE: begin
        if (kp.wait_req) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (!kp.wait_req) begin
          w_state_nxt = IDLE;
        end else if (|w_rise) begin
          w_key_code_nxt = lowest_set(w_rise);
`ifdef KEYPAD_RELEASE_WAIT_EN
          w_state_nxt = HELD;
`else
          w_state_nxt = DONE;
`endif
        end
      end
`ifdef KEYPAD_RELEASE_WAIT_EN
      HELD: begin
        if (!kp.wait_req)                 w_state_nxt = IDLE;
        else if (!w_key_down[r_key_code]) w_state_nxt = DONE;
      end
`endif
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_key_code <= '0;
      r_key_prev <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_key_code <= w_key_code_nxt;
      r_key_prev <= w_key_down;
    end
  end

  assign kp.key_valid = (r_state == DONE);
  assign kp.key_code  = r_key_code;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_chip8_keypad_scan.sv
module tb_chip8_keypad_scan;
  import chip8_keypad_pkg::*;

  localparam int SD = 4;
  localparam int DB = 2;
`ifdef KEYPAD_RELEASE_WAIT_EN
  localparam bit RELEASE = 1'b1;
`else
  localparam bit RELEASE = 1'b0;
`endif
  // Physical layout, position row*4+col -> hex
  localparam logic [3:0] TB_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] key_down;
  logic        any_key;
  state_t      dbg_state;
  logic [15:0] pressed = '0;

  chip8_keypad_scan_if kp_if ();

  chip8_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_row_n     (row_n),
    .i_col_n     (col_n),
    .o_key_down  (key_down),
    .o_any_key   (any_key),
    .kp          (kp_if),
    .o_dbg_state (dbg_state)
  );

  // Keypad matrix: a pressed key shorts its row to its column.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[TB_MAP[r*4+c]]) col_n[c] = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time since reset, per-key disagreement counts, and the FX0A state as an int
  // (0 idle, 1 armed, 2 held, 3 done).
  int          m_cyc;
  int          m_cnt [16];
  logic [15:0] m_down, m_prev;
  logic        m_any;
  int          m_state;
  logic [3:0]  m_code;

  always @(posedge clk or negedge rst_n) begin : model
    logic [15:0] nd;
    logic [15:0] rise;
    logic [3:0]  code;
    int          r;
    int          h;
    if (!rst_n) begin
      m_cyc <= 0; m_down <= '0; m_prev <= '0; m_any <= 1'b0;
      m_state <= 0; m_code <= '0;
      for (int k = 0; k < 16; k++) m_cnt[k] <= 0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_prev <= m_down;
      nd = m_down;
      if (m_cyc % SD == SD - 1) begin
        r = (m_cyc / SD) % 4;
        for (int c = 0; c < 4; c++) begin
          h = TB_MAP[r*4+c];
          if (pressed[h] == m_down[h]) m_cnt[h] <= 0;
          else if (m_cnt[h] + 1 == DB) begin
            m_cnt[h] <= 0;
            nd[h] = ~m_down[h];
          end else m_cnt[h] <= m_cnt[h] + 1;
        end
      end
      m_down <= nd;
      m_any  <= |nd;
      rise = m_down & ~m_prev;
      case (m_state)
        0: if (kp_if.wait_req) m_state <= 1;
        1: begin
          if (!kp_if.wait_req) m_state <= 0;
          else if (rise != 0) begin
            code = 4'h0;
            for (int k = 15; k >= 0; k--) if (rise[k]) code = 4'(k);
            m_code  <= code;
            m_state <= RELEASE ? 2 : 3;
          end
        end
        2: begin
          if (!kp_if.wait_req) m_state <= 0;
          else if (!m_down[m_code]) m_state <= 3;
        end
        default: m_state <= 0;
      endcase
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin : cmp
    logic [3:0] one;
    logic [3:0] exp_row;
    one = 4'b0001;
    exp_row = ~(one << ((m_cyc / SD) % 4));
    chk("row_n", row_n, exp_row);
    chk("key_down", key_down, m_down);
    chk("any_key", any_key, m_any);
    chk("key_valid", kp_if.key_valid, (m_state == 3));
    chk("key_code", kp_if.key_code, m_code);
    chk("fsm_state", dbg_state, m_state);
  end

  // Event monitor for timing relations and sticky observations.
  int   tb_cyc = 0, rise7_cyc = -100, fall7_cyc = -100, pulse_cyc = -100;
  int   pulse_cnt = 0;
  logic prev7 = 1'b0;
  logic seen0 = 1'b0;
  always @(negedge clk) begin
    tb_cyc <= tb_cyc + 1;
    prev7  <= key_down[7];
    if (key_down[7] && !prev7) rise7_cyc <= tb_cyc;
    if (!key_down[7] && prev7) fall7_cyc <= tb_cyc;
    if (kp_if.key_valid) begin
      pulse_cyc <= tb_cyc;
      pulse_cnt <= pulse_cnt + 1;
    end
    if (key_down[0]) seen0 <= 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until the model sits at the given offset within a full scan.
  task automatic align(input int phase);
    int n;
    n = 0;
    @(negedge clk);
    while ((m_cyc % (4*SD)) != phase && n < 4*SD + 2) begin
      @(negedge clk);
      n++;
    end
    chk("align_timeout", (m_cyc % (4*SD)), phase);
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kp_if.key_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic fx0a(input string name, input logic [15:0] mask, input logic [3:0] exp_code);
    bit got;
    int p0;
    p0 = pulse_cnt;
    kp_if.wait_req = 1'b1;
    cycles(2);
    align(0);
    pressed = pressed | mask;
    if (RELEASE) begin
      cycles(48);
      pressed = pressed & ~mask;
    end
    wait_valid(120, got);
    kp_if.wait_req = 1'b0;
    chk({name, "_pulse_seen"}, got, 1'b1);
    chk({name, "_code"}, kp_if.key_code, exp_code);
    pressed = pressed & ~mask;
    cycles(48);
    #1;
    chk({name, "_pulse_count"}, pulse_cnt - p0, 1);
    chk({name, "_released"}, key_down, 16'h0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int p0;
    kp_if.wait_req = 1'b0;

    // 1. reset state and row walk
    cycles(3);
    #1;
    chk("rst_row_n", row_n, 4'b1110);
    chk("rst_key_down", key_down, 16'h0000);
    chk("rst_any_key", any_key, 1'b0);
    chk("rst_key_valid", kp_if.key_valid, 1'b0);
    chk("rst_key_code", kp_if.key_code, 4'h0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(4);  chk("walk_row1", row_n, 4'b1101);
    cycles(4);  chk("walk_row2", row_n, 4'b1011);
    cycles(4);  chk("walk_row3", row_n, 4'b0111);
    cycles(4);  chk("walk_wrap", row_n, 4'b1110);
    chk("walk_no_keys", key_down, 16'h0000);

    // 2. key 6 (row1/col2) held three scans, then released three scans
    pressed[6] = 1'b1;
    cycles(48);
    chk("key6_down", key_down, 16'h0040);
    chk("key6_any", any_key, 1'b1);
    pressed[6] = 1'b0;
    cycles(48);
    chk("key6_up", key_down, 16'h0000);
    chk("key6_any_up", any_key, 1'b0);

    // 3. one-sample glitch on key 0 (row3/col1): pressed across exactly one row3 sample
    align(8);
    pressed[0] = 1'b1;
    cycles(8);
    pressed[0] = 1'b0;
    cycles(40);
    #1;
    chk("glitch_never_set", seen0, 1'b0);
    chk("glitch_key_down", key_down, 16'h0000);

    // 4. FX0A on key 7, with the pulse timed against the key_down edge
    fx0a("key7", 16'h0080, 4'h7);
    if (RELEASE) chk("key7_pulse_after_fall", pulse_cyc - fall7_cyc, 1);
    else         chk("key7_pulse_after_rise", pulse_cyc - rise7_cyc, 1);

    // 5. two keys pressed together: different rows, then the same row
    fx0a("keys2_9", 16'h0204, 4'h2);
    fx0a("keys8_9", 16'h0300, 4'h8);

    // 6a. key 5 already down before the request never completes it; abort
    pressed[5] = 1'b1;
    cycles(48);
    chk("key5_down", key_down, 16'h0020);
    p0 = pulse_cnt;
    kp_if.wait_req = 1'b1;
    cycles(40);
    #1;
    chk("key5_armed", dbg_state, ARMED);
    chk("key5_no_pulse", pulse_cnt - p0, 0);
    kp_if.wait_req = 1'b0;
    cycles(2);
    #1;
    chk("abort_idle", dbg_state, IDLE);
    chk("abort_no_pulse", pulse_cnt - p0, 0);
    chk("abort_code_kept", kp_if.key_code, 4'h8);
    pressed[5] = 1'b0;
    cycles(48);

    // 6b. reset while waiting (HELD with the macro, ARMED without)
    if (RELEASE) begin
      kp_if.wait_req = 1'b1;
      cycles(2);
      pressed[4'hA] = 1'b1;
      cycles(48);
      chk("pre_rst_state", dbg_state, HELD);
    end else begin
      pressed[4'hA] = 1'b1;
      cycles(48);
      kp_if.wait_req = 1'b1;
      cycles(4);
      chk("pre_rst_state", dbg_state, ARMED);
    end
    chk("pre_rst_keyA", key_down, 16'h0400);
    cycles(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_key_down", key_down, 16'h0000);
    chk("midrst_any_key", any_key, 1'b0);
    chk("midrst_row_n", row_n, 4'b1110);
    chk("midrst_state", dbg_state, IDLE);
    chk("midrst_key_code", kp_if.key_code, 4'h0);
    kp_if.wait_req = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(48);
    chk("post_rst_keyA", key_down, 16'h0400);
    pressed = '0;
    cycles(48);
    chk("final_idle", key_down, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
